// File: rtl/fft_sched.sv
// Two-requester block scheduler in front of a streaming FFT core.
// Grants whole blocks of 2^ldn samples round-robin, forwards the grantee's
// samples with one cycle of latency, and enforces an idle gap between blocks.
module fft_sched #(
  parameter int unsigned DW      = 16,
  parameter int unsigned GAP_CYC = 4
) (
  input  logic          clk_sys,
  input  logic          rst_sys,
  input  logic [1:0]    req_i,
  input  logic [3:0]    ldn0_i,
  input  logic [3:0]    ldn1_i,
  input  logic [1:0]    src_valid_i,
  output logic [1:0]    src_ready_o,
  input  logic [DW-1:0] src0_real_i,
  input  logic [DW-1:0] src0_imag_i,
  input  logic [DW-1:0] src1_real_i,
  input  logic [DW-1:0] src1_imag_i,
  output logic [1:0]    grant_o,
  output logic          block_sync_o,
  output logic          data_val_o,
  output logic [DW-1:0] data_real_o,
  output logic [DW-1:0] data_imag_o,
  output logic [3:0]    ldn_rg_o,
  output logic          done_o,
  output logic [1:0]    err_o,
  output logic          busy_o
);

  localparam int unsigned CW = 11;
  localparam int unsigned GW = 4;
  localparam logic [3:0] LDN_MIN = 4'd3;
  localparam logic [3:0] LDN_MAX = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gap_cnt;
  logic          last_gnt;

  logic [1:0]    size_ok_c;
  logic [1:0]    legal_c;
  logic          sel_c;
  logic [1:0]    sel_oh_c;
  logic [3:0]    sel_ldn_c;
  logic          xfer_c;
  logic [CW-1:0] last_idx_c;
  logic          last_c;
  logic          gap_end_c;
  logic [DW-1:0] samp_re_c;
  logic [DW-1:0] samp_im_c;

  // State register
  always_ff @(posedge clk_sys) begin
    if (rst_sys) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|legal_c) state_nxt = RUN;
      RUN:     if (xfer_c && last_c) state_nxt = GAP;
      GAP:     if (gap_end_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request qualification, arbitration and transfer decode
  always_comb begin
    size_ok_c[0] = (ldn0_i >= LDN_MIN) && (ldn0_i <= LDN_MAX);
    size_ok_c[1] = (ldn1_i >= LDN_MIN) && (ldn1_i <= LDN_MAX);
    legal_c      = req_i & size_ok_c;
    // Tie goes to the requester that was not granted last
    if (legal_c == 2'b11) sel_c = ~last_gnt;
    else                  sel_c = legal_c[1];
    sel_oh_c     = sel_c ? 2'b10 : 2'b01;
    sel_ldn_c    = sel_c ? ldn1_i : ldn0_i;
    xfer_c       = |(src_ready_o & src_valid_i);
    last_idx_c   = CW'((12'd1 << ldn_rg_o) - 12'd1);
    last_c       = (cnt == last_idx_c);
    gap_end_c    = (gap_cnt == GW'(GAP_CYC - 1));
    samp_re_c    = grant_o[1] ? src1_real_i : src0_real_i;
    samp_im_c    = grant_o[1] ? src1_imag_i : src0_imag_i;
  end

  // Registered outputs, sample counter, gap timer and arbitration history
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      src_ready_o  <= 2'b00;
      grant_o      <= 2'b00;
      block_sync_o <= 1'b0;
      data_val_o   <= 1'b0;
      data_real_o  <= '0;
      data_imag_o  <= '0;
      ldn_rg_o     <= 4'd0;
      done_o       <= 1'b0;
      err_o        <= 2'b00;
      busy_o       <= 1'b0;
      cnt          <= '0;
      gap_cnt      <= '0;
      last_gnt     <= 1'b1;
    end else begin
      err_o        <= req_i & ~size_ok_c;
      busy_o       <= (state_nxt != IDLE);
      data_val_o   <= xfer_c;
      block_sync_o <= xfer_c && (cnt == '0);
      done_o       <= xfer_c && last_c;
      if (xfer_c) begin
        data_real_o <= samp_re_c;
        data_imag_o <= samp_im_c;
        cnt         <= cnt + CW'(1);
      end
      case (state)
        IDLE: begin
          if (|legal_c) begin
            grant_o     <= sel_oh_c;
            src_ready_o <= sel_oh_c;
            ldn_rg_o    <= sel_ldn_c;
            cnt         <= '0;
            last_gnt    <= sel_c;
          end
        end
        RUN: begin
          if (xfer_c && last_c) begin
            grant_o     <= 2'b00;
            src_ready_o <= 2'b00;
            gap_cnt     <= '0;
          end
        end
        GAP:     gap_cnt <= gap_cnt + GW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_sched.sv
// Directed bench for fft_sched: a scoreboard queue holds every accepted
// sample with its expected sync/done flags and is drained as data_val_o fires.
module tb_fft_sched;

  localparam int unsigned DW  = 16;
  localparam int unsigned GAP = 4;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          sync;
    logic          done;
  } exp_t;

  logic          clk_sys = 1'b0;
  logic          rst_sys = 1'b0;
  logic [1:0]    req_i = 2'b00;
  logic [3:0]    ldn0_i = 4'd0;
  logic [3:0]    ldn1_i = 4'd0;
  logic [1:0]    src_valid_i = 2'b00;
  logic [1:0]    src_ready_o;
  logic [DW-1:0] src0_real_i = '0;
  logic [DW-1:0] src0_imag_i = '0;
  logic [DW-1:0] src1_real_i = '0;
  logic [DW-1:0] src1_imag_i = '0;
  logic [1:0]    grant_o;
  logic          block_sync_o;
  logic          data_val_o;
  logic [DW-1:0] data_real_o;
  logic [DW-1:0] data_imag_o;
  logic [3:0]    ldn_rg_o;
  logic          done_o;
  logic [1:0]    err_o;
  logic          busy_o;

  fft_sched #(.DW(DW), .GAP_CYC(GAP)) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .req_i(req_i),
    .ldn0_i(ldn0_i), .ldn1_i(ldn1_i), .src_valid_i(src_valid_i),
    .src_ready_o(src_ready_o), .src0_real_i(src0_real_i),
    .src0_imag_i(src0_imag_i), .src1_real_i(src1_real_i),
    .src1_imag_i(src1_imag_i), .grant_o(grant_o),
    .block_sync_o(block_sync_o), .data_val_o(data_val_o),
    .data_real_o(data_real_o), .data_imag_o(data_imag_o),
    .ldn_rg_o(ldn_rg_o), .done_o(done_o), .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk_sys = ~clk_sys;

  int   npass = 0;
  int   ntot  = 0;
  int   cyc   = 0;
  int   n_val = 0;
  int   n_done = 0;
  int   n_sync = 0;
  int   done_cyc = -1;
  int   bidx = 0;
  int   blk_n [2] = '{8, 8};
  int   seq0 = 0;
  int   seq1 = 0;
  bit   gap_chk = 1'b0;
  bit   tog0 = 1'b0;
  exp_t sb [$];
  logic [1:0] glog [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive_samples();
    src0_real_i = DW'(seq0 * 3 + 1);
    src0_imag_i = DW'(16'hF000 - seq0);
    src1_real_i = DW'(16'h4000 + seq1 * 5);
    src1_imag_i = DW'(16'h0800 + seq1);
  endtask

  // One clock: predict the transfer, advance, then check the registered outputs
  task automatic tick();
    logic x0, x1;
    logic [1:0] prev_rdy;
    exp_t e, got;
    int r;
    x0 = src_ready_o[0] & src_valid_i[0];
    x1 = src_ready_o[1] & src_valid_i[1];
    if (x0 | x1) begin
      r      = x1 ? 1 : 0;
      e.re   = x1 ? src1_real_i : src0_real_i;
      e.im   = x1 ? src1_imag_i : src0_imag_i;
      e.sync = (bidx == 0);
      e.done = (bidx == blk_n[r] - 1);
      sb.push_back(e);
      bidx = (bidx == blk_n[r] - 1) ? 0 : bidx + 1;
    end
    prev_rdy = src_ready_o;
    @(posedge clk_sys);
    #1;
    cyc++;
    chk("data_val", 32'(data_val_o), 32'(x0 | x1));
    if (data_val_o === 1'b1) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        got = sb.pop_front();
        chk("data_real", 32'(data_real_o), 32'(got.re));
        chk("data_imag", 32'(data_imag_o), 32'(got.im));
        chk("block_sync", 32'(block_sync_o), 32'(got.sync));
        chk("done", 32'(done_o), 32'(got.done));
      end
      n_val++;
    end else begin
      chk("sync_idle", 32'(block_sync_o), 32'd0);
      chk("done_idle", 32'(done_o), 32'd0);
    end
    if (block_sync_o === 1'b1) n_sync++;
    if (prev_rdy == 2'b00 && src_ready_o != 2'b00) begin
      glog.push_back(grant_o);
      if (gap_chk && done_cyc >= 0) chk("gap_len", 32'(cyc - done_cyc), 32'(GAP + 1));
    end
    if (done_o === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end
    if (x0) seq0++;
    if (x1) seq1++;
    drive_samples();
    if (tog0) src_valid_i[0] = ~src_valid_i[0];
  endtask

  task automatic run_until_done(input int limit);
    int start, i;
    start = n_done;
    i = 0;
    while (n_done == start && i < limit) begin
      tick();
      i++;
    end
    chk("done_timeout", 32'(n_done != start), 32'd1);
  endtask

  task automatic do_reset();
    rst_sys = 1'b1;
    @(posedge clk_sys);
    #1;
    cyc++;
    rst_sys = 1'b0;
    chk("rst_ready", 32'(src_ready_o), 32'd0);
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_sync", 32'(block_sync_o), 32'd0);
    chk("rst_val", 32'(data_val_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_real", 32'(data_real_o), 32'd0);
    chk("rst_imag", 32'(data_imag_o), 32'd0);
    chk("rst_ldn", 32'(ldn_rg_o), 32'd0);
    sb.delete();
    bidx = 0;
  endtask

  initial begin
    int v0, s0;
    drive_samples();
    do_reset();

    // Single 8-point block from requester 0
    blk_n[0] = 8; ldn0_i = 4'd3; req_i = 2'b01; src_valid_i = 2'b01;
    n_val = 0; n_sync = 0;
    tick();
    chk("a_grant", 32'(grant_o), 32'h1);
    chk("a_ready", 32'(src_ready_o), 32'h1);
    chk("a_busy", 32'(busy_o), 32'd1);
    chk("a_ldn", 32'(ldn_rg_o), 32'd3);
    req_i = 2'b00;
    run_until_done(40);
    chk("a_nval", 32'(n_val), 32'd8);
    chk("a_nsync", 32'(n_sync), 32'd1);
    chk("a_ldn_end", 32'(ldn_rg_o), 32'd3);
    chk("a_grant_gap", 32'(grant_o), 32'd0);
    chk("a_ready_gap", 32'(src_ready_o), 32'd0);
    for (int i = 0; i < int'(GAP) - 1; i++) tick();
    chk("a_busy_gap_end", 32'(busy_o), 32'd1);
    tick();
    chk("a_busy_idle", 32'(busy_o), 32'd0);

    // Round-robin between two requesters holding their requests
    do_reset();
    blk_n[0] = 16; blk_n[1] = 16; ldn0_i = 4'd4; ldn1_i = 4'd4;
    req_i = 2'b11; src_valid_i = 2'b11;
    glog.delete(); gap_chk = 1'b1; done_cyc = -1;
    for (int b = 0; b < 3; b++) begin
      run_until_done(200);
      if (glog.size() >= 3) req_i = 2'b00;
    end
    gap_chk = 1'b0;
    req_i = 2'b00;
    chk("rr_count", 32'(glog.size()), 32'd3);
    if (glog.size() >= 3) begin
      chk("rr_first", 32'(glog[0]), 32'h1);
      chk("rr_second", 32'(glog[1]), 32'h2);
      chk("rr_third", 32'(glog[2]), 32'h1);
    end
    for (int i = 0; i < int'(GAP) + 2; i++) tick();
    chk("rr_idle", 32'(busy_o), 32'd0);

    // 128-point block with source valid toggling every cycle
    blk_n[0] = 128; ldn0_i = 4'd7; req_i = 2'b01; src_valid_i = 2'b00;
    n_val = 0; n_sync = 0; tog0 = 1'b1;
    tick();
    req_i = 2'b00;
    run_until_done(600);
    tog0 = 1'b0;
    chk("b_nval", 32'(n_val), 32'd128);
    chk("b_nsync", 32'(n_sync), 32'd1);
    for (int i = 0; i < int'(GAP) + 2; i++) tick();

    // Illegal size codes are flagged and never granted
    src_valid_i = 2'b11;
    req_i = 2'b01; ldn0_i = 4'd12;
    tick();
    chk("e_err12", 32'(err_o), 32'h1);
    chk("e_busy12", 32'(busy_o), 32'd0);
    chk("e_grant12", 32'(grant_o), 32'd0);
    ldn0_i = 4'd2;
    tick();
    chk("e_err2", 32'(err_o), 32'h1);
    chk("e_busy2", 32'(busy_o), 32'd0);
    chk("e_grant2", 32'(grant_o), 32'd0);
    req_i = 2'b10; ldn0_i = 4'd3; ldn1_i = 4'd0;
    tick();
    chk("e_err1", 32'(err_o), 32'h2);
    chk("e_grant1", 32'(grant_o), 32'd0);
    req_i = 2'b00;
    tick();
    chk("e_err_clr", 32'(err_o), 32'd0);

    // Reset in the middle of a 16-point block, then a fresh block
    blk_n[0] = 16; ldn0_i = 4'd4; req_i = 2'b01; src_valid_i = 2'b01;
    n_val = 0;
    v0 = 0;
    while (n_val < 5 && v0 < 40) begin
      tick();
      v0++;
    end
    chk("r_pre_nval", 32'(n_val), 32'd5);
    do_reset();
    n_val = 0; n_sync = 0;
    tick();
    chk("r_regrant", 32'(grant_o), 32'h1);
    req_i = 2'b00;
    run_until_done(60);
    chk("r_nval", 32'(n_val), 32'd16);
    chk("r_nsync", 32'(n_sync), 32'd1);
    for (int i = 0; i < int'(GAP) + 2; i++) tick();

    // Size code changed mid-block has no effect on the running block
    blk_n[0] = 16; ldn0_i = 4'd4; req_i = 2'b01; src_valid_i = 2'b01;
    n_val = 0;
    tick();
    req_i = 2'b00;
    for (int i = 0; i < 4; i++) tick();
    ldn0_i = 4'd11;
    s0 = n_done;
    run_until_done(60);
    chk("l_ldn_hold", 32'(ldn_rg_o), 32'd4);
    chk("l_nval", 32'(n_val), 32'd16);
    chk("l_one_done", 32'(n_done - s0), 32'd1);
    for (int i = 0; i < int'(GAP) + 2; i++) tick();
    chk("l_idle", 32'(busy_o), 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
